// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard/stall controller.
package pipe_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    typedef logic [3:0] reg_idx_t;
    localparam int DRAIN_CYCLES_DEFAULT = 3;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from the datapath and stage controls back to it.
interface pipeline_ctrl_if import pipe_pkg::*; #(parameter int CNT_W = 16);
    reg_idx_t id_rs;
    reg_idx_t id_rt;
    reg_idx_t ex_reg_write_select;
    logic id_uses_rs;
    logic id_uses_rt;
    logic id_halt;
    logic ex_memtoreg;
    logic ex_regwrite;
    logic ex_branch_taken;
    logic imem_busy;
    logic dmem_busy;
    logic pc_wen;
    logic ifid_wen;
    logic ifid_flush;
    logic idex_wen;
    logic idex_flush;
    logic exmem_wen;
    logic memwb_wen;
    logic halted;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output id_rs, id_rt, ex_reg_write_select, id_uses_rs, id_uses_rt, id_halt,
               ex_memtoreg, ex_regwrite, ex_branch_taken, imem_busy, dmem_busy,
        input  pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen,
               memwb_wen, halted, stall_cnt
    );
    modport slave (
        input  id_rs, id_rt, ex_reg_write_select, id_uses_rs, id_uses_rt, id_halt,
               ex_memtoreg, ex_regwrite, ex_branch_taken, imem_busy, dmem_busy,
        output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen,
               memwb_wen, halted, stall_cnt
    );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: load-use compare between the ID sources and a load in EX; R0 never hazards.
module hazard_detect import pipe_pkg::*; (
    input  reg_idx_t rs,
    input  reg_idx_t rt,
    input  logic     uses_rs,
    input  logic     uses_rt,
    input  logic     ex_memtoreg,
    input  logic     ex_regwrite,
    input  reg_idx_t ex_rd,
    output logic     load_use
);
    assign load_use = ex_memtoreg && ex_regwrite && (ex_rd != '0) &&
                      ((uses_rs && rs == ex_rd) || (uses_rt && rt == ex_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush control for the five-stage pipe, HLT drain FSM and saturating stall counter.
module pipeline_ctrl import pipe_pkg::*; #(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);
    state_t           state;
    logic [2:0]       dcnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             load_use;
    logic             go;
    logic             draining;
    hazard_detect u_hazard (
        .rs          (bus.id_rs),
        .rt          (bus.id_rt),
        .uses_rs     (bus.id_uses_rs),
        .uses_rt     (bus.id_uses_rt),
        .ex_memtoreg (bus.ex_memtoreg),
        .ex_regwrite (bus.ex_regwrite),
        .ex_rd       (bus.ex_reg_write_select),
        .load_use    (load_use)
    );
    assign go       = !rst && state != HALTED && !bus.dmem_busy;
    assign draining = state == DRAIN;
    // a taken branch overrides every stall; fetch is blocked while HLT is in ID or draining
    assign bus.pc_wen     = go && (bus.ex_branch_taken ||
                            (!load_use && !bus.imem_busy && !draining && !bus.id_halt));
    assign bus.ifid_wen   = go && (bus.ex_branch_taken || !load_use);
    assign bus.ifid_flush = go && (bus.ex_branch_taken ||
                            (!load_use && (bus.imem_busy || draining || bus.id_halt)));
    assign bus.idex_wen   = go;
    assign bus.idex_flush = go && (bus.ex_branch_taken || load_use);
    assign bus.exmem_wen  = go;
    assign bus.memwb_wen  = go;
    assign bus.halted     = state == HALTED && !rst;
    assign bus.stall_cnt  = stall_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            dcnt      <= '0;
            stall_cnt <= '0;
        end else begin
            if (!bus.pc_wen && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (go) begin
                if (bus.ex_branch_taken) begin
                    state <= RUN;
                    dcnt  <= '0;
                end else if (draining) begin
                    dcnt  <= dcnt - 3'd1;
                    state <= (dcnt == 3'd1) ? HALTED : DRAIN;
                end else if (bus.id_halt && !load_use) begin
                    state <= DRAIN;
                    dcnt  <= 3'(DRAIN_CYCLES);
                end
            end
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a behavioural model.
module tb_pipeline_ctrl;
    import pipe_pkg::*;
    localparam int DC      = 3;
    localparam int CW      = 16;
    localparam int CNT_MAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0, passed = 0, fails = 0;
    bit m_halted = 1'b0;
    int m_drain = 0;
    int m_cnt = 0;
    pipeline_ctrl_if #(.CNT_W(CW)) bus ();
    pipeline_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic bit ref_lu();
        return bus.ex_memtoreg && bus.ex_regwrite && bus.ex_reg_write_select != 0 &&
               ((bus.id_uses_rs && bus.id_rs == bus.ex_reg_write_select) ||
                (bus.id_uses_rt && bus.id_rt == bus.ex_reg_write_select));
    endfunction

    // {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, memwb_wen, halted}
    function automatic logic [7:0] expect_ctrl();
        bit stop;
        if (rst) return 8'b0000_0000;
        if (m_halted) return 8'b0000_0001;
        if (bus.dmem_busy) return 8'b0000_0000;
        if (bus.ex_branch_taken) return 8'b1111_1110;
        if (ref_lu()) return 8'b0001_1110;
        stop = bus.imem_busy || m_drain > 0 || bus.id_halt;
        return {!stop, 1'b1, stop, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    endfunction

    task automatic expect_eq(input string tag, input int o, input int e);
        total++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s got %0d want %0d", tag, o, e);
        end
    endtask

    task automatic check(input string tag);
        logic [7:0] e;
        logic [7:0] o;
        e = expect_ctrl();
        o = {bus.pc_wen, bus.ifid_wen, bus.ifid_flush, bus.idex_wen, bus.idex_flush,
             bus.exmem_wen, bus.memwb_wen, bus.halted};
        total++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s ctrl got %b want %b", tag, o, e);
        end
        total++;
        assert (bus.stall_cnt === CW'(m_cnt)) passed++;
        else begin
            fails++;
            $error("FAIL %s stall_cnt got %0d want %0d", tag, bus.stall_cnt, m_cnt);
        end
    endtask

    task automatic advance();
        logic [7:0] e;
        e = expect_ctrl();
        if (rst) begin
            m_halted = 1'b0;
            m_drain  = 0;
            m_cnt    = 0;
        end else begin
            if (!e[7] && m_cnt < CNT_MAX) m_cnt++;
            if (!m_halted && !bus.dmem_busy) begin
                if (bus.ex_branch_taken) m_drain = 0;
                else if (m_drain > 0) begin
                    m_drain--;
                    if (m_drain == 0) m_halted = 1'b1;
                end else if (bus.id_halt && !ref_lu()) m_drain = DC;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        #1;
        check(tag);
        advance();
    endtask

    task automatic clear_in();
        bus.id_rs = '0; bus.id_rt = '0; bus.ex_reg_write_select = '0;
        bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.id_halt = 0;
        bus.ex_memtoreg = 0; bus.ex_regwrite = 0; bus.ex_branch_taken = 0;
        bus.imem_busy = 0; bus.dmem_busy = 0;
    endtask

    task automatic set_lu();
        bus.ex_memtoreg = 1; bus.ex_regwrite = 1; bus.ex_reg_write_select = 4'd3;
        bus.id_rs = 4'd3; bus.id_uses_rs = 1;
    endtask

    initial begin
        int n;
        clear_in();
        @(negedge clk);
        step("reset0");
        step("reset1");
        rst = 0;
        set_lu();
        step("load_use");
        clear_in();
        #1 expect_eq("lu_cnt", int'(bus.stall_cnt), 1);
        expect_eq("lu_after_pc_wen", int'(bus.pc_wen), 1);
        step("lu_release");
        set_lu(); bus.ex_reg_write_select = 4'd0; bus.id_rs = 4'd0;
        step("r0_no_hazard");
        set_lu(); bus.id_uses_rs = 0;
        step("rs_unused");
        set_lu(); bus.ex_branch_taken = 1; bus.imem_busy = 1;
        step("br_lu_imem");
        clear_in();
        #1 expect_eq("br_cnt", int'(bus.stall_cnt), 1);
        set_lu(); bus.dmem_busy = 1;
        for (int i = 0; i < 4; i++) step("dmem_freeze");
        bus.dmem_busy = 0;
        step("lu_after_freeze");
        clear_in();
        #1 expect_eq("freeze_cnt", int'(bus.stall_cnt), 6);
        step("idle");
        n = 0;
        bus.id_halt = 1;
        while (!bus.halted && n < 20) begin
            step("drain");
            bus.id_halt = 0;
            n++;
        end
        expect_eq("drain_len", n, 1 + DC);
        bus.imem_busy = 1; bus.ex_branch_taken = 1;
        step("halted_ignores");
        clear_in();
        rst = 1;
        step("rst_in_halted");
        rst = 0;
        #1 expect_eq("rst_halted", int'(bus.halted), 0);
        expect_eq("rst_cnt", int'(bus.stall_cnt), 0);
        n = 0;
        bus.id_halt = 1;
        while (!bus.halted && n < 20) begin
            bus.dmem_busy = (n == 2 || n == 3);
            step("drain_frz");
            bus.id_halt = 0;
            n++;
        end
        bus.dmem_busy = 0;
        expect_eq("drain_frz_len", n, 3 + DC);
        rst = 1;
        step("rst2");
        rst = 0;
        bus.id_halt = 1;
        step("halt_then_br");
        bus.id_halt = 0; bus.ex_branch_taken = 1;
        step("wrong_path_halt");
        clear_in();
        for (int i = 0; i < 6; i++) step("post_br");
        #1 expect_eq("br_not_halted", int'(bus.halted), 0);
        expect_eq("br_pc_wen", int'(bus.pc_wen), 1);
        for (int i = 0; i < 2000; i++) begin
            rst                     = ($urandom_range(199) == 0);
            bus.id_rs               = 4'($urandom_range(3));
            bus.id_rt               = 4'($urandom_range(3));
            bus.ex_reg_write_select = 4'($urandom_range(3));
            bus.id_uses_rs          = 1'($urandom);
            bus.id_uses_rt          = 1'($urandom);
            bus.ex_memtoreg         = 1'($urandom);
            bus.ex_regwrite         = 1'($urandom);
            bus.id_halt             = ($urandom_range(14) == 0);
            bus.ex_branch_taken     = ($urandom_range(9) == 0);
            bus.imem_busy           = ($urandom_range(4) == 0);
            bus.dmem_busy           = ($urandom_range(5) == 0);
            step("random");
        end
        clear_in();
        rst = 1;
        step("rst_sat");
        rst = 0;
        bus.imem_busy = 1;
        for (int i = 0; i < CNT_MAX + 6; i++) advance();
        step("saturate");
        #1 expect_eq("sat_cnt", int'(bus.stall_cnt), CNT_MAX);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and stall controller for the 16-bit five-stage pipeline. It generates the write-enable and flush controls for the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch squashes, instruction/data memory wait states and the HLT drain sequence. It also keeps a saturating stall-cycle counter for debug.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles the pipeline keeps retiring after HLT leaves ID before the core freezes (1..7)
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high
- id_rs  in  4  source register 1 of the instruction in ID
- id_rt  in  4  source register 2 of the instruction in ID
- id_uses_rs  in  1  ID instruction reads id_rs
- id_uses_rt  in  1  ID instruction reads id_rt
- id_halt  in  1  ID instruction is HLT
- ex_memtoreg  in  1  ID/EX holds a load
- ex_regwrite  in  1  ID/EX instruction writes a register
- ex_reg_write_select  in  4  destination register of ID/EX instruction
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- imem_busy  in  1  instruction fetch not complete this cycle
- dmem_busy  in  1  data access in MEM not complete this cycle
- pc_wen  out  1  PC register write enable
- ifid_wen  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID loads a NOP (0x0000-control bubble) instead of its input
- idex_wen  out  1  ID/EX write enable
- idex_flush  out  1  ID/EX loads all-zero controls (regwrite/memwrite/memtoreg = 0)
- exmem_wen  out  1  EX/MEM write enable
- memwb_wen  out  1  MEM/WB write enable
- halted  out  1  core frozen after HLT
- stall_cnt  out  CNT_W  cycles in which pc_wen was 0, saturating

## Operation
States: RUN, DRAIN, HALTED. Flush takes effect only when the matching wen is 1.
- load_use = ex_memtoreg & ex_regwrite & (ex_reg_write_select != 0) & ((id_uses_rs & id_rs == ex_reg_write_select) | (id_uses_rt & id_rt == ex_reg_write_select)). R0 never hazards.
- Priority, highest first, in RUN and DRAIN:
  1. dmem_busy: every wen = 0, flushes = 0. Whole pipe frozen. State and counter hold.
  2. ex_branch_taken: all wen = 1, ifid_flush = 1, idex_flush = 1. In DRAIN this returns to RUN, because the HLT was on the wrong path.
  3. load_use: pc_wen = 0, ifid_wen = 0, idex_flush = 1. The rest advance. This is a one-bubble stall.
  4. imem_busy: pc_wen = 0, ifid_flush = 1. The rest advance.
  5. Otherwise all wen = 1, flushes = 0.
- RUN to DRAIN: when id_halt and case 5 or 4 applies.
  - On entry, drain counter = DRAIN_CYCLES, and the HLT advances into ID/EX normally.
  - pc_wen = 0 and ifid_flush = 1 in that cycle.
- DRAIN behaviour:
  - pc_wen = 0 and ifid_flush = 1 in every non-frozen cycle.
  - The downstream registers advance.
  - The counter decrements on each non-frozen cycle.
  - The cycle in which the counter reads 1 and decrements leads to HALTED.
- HALTED: every wen = 0, flushes = 0, halted = 1. Exits only on rst. All inputs are ignored.
- stall_cnt increments on every cycle in which pc_wen = 0 and rst = 0. It saturates at all-ones.

## Timing
- Control outputs are combinational from state and the current-cycle inputs, and are valid before the clk edge that uses them. The halted state and stall_cnt are registered.
- While rst = 1:
  - all wen = 0, flushes = 0, halted = 0.
  - Next state is RUN, drain counter = 0, stall_cnt = 0 at the edge.
- Reset mid-DRAIN or in HALTED returns to RUN on the following cycle.
- Load-use latency is exactly one bubble; the dependent instruction reaches EX one cycle after the load leaves EX.
- Simultaneous events:
  - dmem_busy with branch: freeze wins, and the branch is reapplied when busy drops.
  - Branch with load_use: flush wins, no stall.
  - load_use with imem_busy: load_use outputs, with ifid_flush = 0.
  - id_halt with load_use: stall first, then HLT is evaluated again next cycle.
- From HLT in ID to halted = 1 takes 1 + DRAIN_CYCLES non-frozen cycles.

## Structure
- Shared package pipe_pkg: state enum {RUN, DRAIN, HALTED}, register-index type (4-bit), and the DRAIN_CYCLES default constant.
- One sub-module, hazard_detect, holds the combinational load_use compare so that the forwarding unit can reuse it.
- FSM, drain counter and stall counter live in pipeline_ctrl.

## Test plan
- Load R3 in EX (ex_memtoreg=1, ex_reg_write_select=3), ID uses rs=3 -> one cycle with pc_wen=0, ifid_wen=0, idex_flush=1; next cycle all wen=1; stall_cnt=1.
- Same as the first case but ex_reg_write_select=0 -> no stall; and with id_uses_rs=0 -> no stall.
- ex_branch_taken with load_use and imem_busy all 1 -> all wen=1, ifid_flush=1, idex_flush=1, stall_cnt unchanged.
- dmem_busy held 4 cycles during load_use -> 4 cycles all wen=0, then the single load-use bubble; stall_cnt=5.
- id_halt in RUN, DRAIN_CYCLES=3, no stalls -> halted=1 after 4 cycles, all wen=0 thereafter. Repeat with dmem_busy for 2 cycles mid-drain -> 6 cycles.
- id_halt then ex_branch_taken in the next cycle -> back to RUN, halted stays 0. rst asserted in HALTED -> RUN, halted=0, stall_cnt=0 next cycle. Force 2^CNT_W+5 stall cycles -> stall_cnt stays 0xFFFF.
